mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory slave with programmable wait states.
// A request accepted in IDLE is held through WAIT_CYCLES wait states and then
// completed in a one-cycle RESP state that pulses ready. Requests seen while
// busy are dropped; there is no queueing.
// Optional build macro MEM_RESP_ERR_EN adds out-of-range detection on
// addr[15:ADDR_W]. Such accesses drive err in RESP and return 32'hDEAD_BEEF
// for reads, and they leave memory unchanged.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
`ifdef MEM_RESP_ERR_EN
    output logic        err,
`endif
    output logic        ready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_hold;
    logic                oor;      // out-of-range flag of the incoming address
    logic                oor_q;    // latched with the access
    logic [31:0]         mem [2**ADDR_W];

    // Upper address bits: checked when the range option is built in,
    // otherwise dropped so addresses alias modulo the depth.
    generate
        if (ADDR_W < 16) begin : g_hi
`ifdef MEM_RESP_ERR_EN
            assign oor = |addr[15:ADDR_W];
`else
            logic unused_hi;
            assign unused_hi = ^addr[15:ADDR_W];
            assign oor       = 1'b0;
`endif
        end else begin : g_nohi
            assign oor = 1'b0;
        end
    endgenerate

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one-cycle RESP.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (req) begin
                if (WAIT_CYCLES == 0) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = WAIT_LOAD;
                end
            end
            WAIT: if (cnt == 4'd0) state_nxt = RESP;
                  else             cnt_nxt   = cnt - 4'd1;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the access attributes at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            oor_q   <= 1'b0;
        end else if (state == IDLE && req) begin
            rw_q    <= rw;
            addr_q  <= addr[ADDR_W-1:0];
            wdata_q <= wdata;
            oor_q   <= oor;
        end
    end

    // Hold the last read response so rdata stays stable between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     rdata_hold <= 32'h0;
        else if (state == RESP && rw_q) rdata_hold <= rdata;
    end

    // Write commits at the edge that ends RESP; an aborted access never
    // reaches RESP, so reset suppresses the write. Storage is not reset.
    always_ff @(posedge clk) begin
        if (state == RESP && !rw_q && !oor_q) mem[addr_q] <= wdata_q;
    end

    // Response outputs.
    always_comb begin
        rdata = rdata_hold;
        if (state == RESP && rw_q) rdata = oor_q ? 32'hDEAD_BEEF : mem[addr_q];
    end

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);
`ifdef MEM_RESP_ERR_EN
    assign err   = (state == RESP) && oor_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_CYCLES = 2, 0, 1
// share clock and reset; each task exercises one behaviour and checks inline.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic        req_a = 0, rw_a = 0, ready_a, busy_a;
    logic [15:0] addr_a = 0;
    logic [31:0] wdata_a = 0, rdata_a;
    logic        req_b = 0, rw_b = 0, ready_b, busy_b;
    logic [15:0] addr_b = 0;
    logic [31:0] wdata_b = 0, rdata_b;
    logic        req_c = 0, rw_c = 0, ready_c, busy_c;
    logic [15:0] addr_c = 0;
    logic [31:0] wdata_c = 0, rdata_c;
`ifdef MEM_RESP_ERR_EN
    logic        err_a, err_b, err_c;
`endif

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .rw(rw_a), .addr(addr_a), .wdata(wdata_a),
        .rdata(rdata_a),
`ifdef MEM_RESP_ERR_EN
        .err(err_a),
`endif
        .ready(ready_a), .busy(busy_a));

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .rw(rw_b), .addr(addr_b), .wdata(wdata_b),
        .rdata(rdata_b),
`ifdef MEM_RESP_ERR_EN
        .err(err_b),
`endif
        .ready(ready_b), .busy(busy_b));

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .rw(rw_c), .addr(addr_c), .wdata(wdata_c),
        .rdata(rdata_c),
`ifdef MEM_RESP_ERR_EN
        .err(err_c),
`endif
        .ready(ready_c), .busy(busy_c));

    // Present a one-edge request to instance A.
    task automatic drive_a(input logic r, input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        req_a = 1'b1; rw_a = r; addr_a = a; wdata_a = d;
        @(posedge clk);
        #1 req_a = 1'b0;
    endtask

    // Cycles from acceptance edge to the first cycle showing ready (bounded).
    task automatic wait_ready_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_a && n < 12);
    endtask

    task automatic test_reset;
        #2;
        vectors++;
        if ({busy_a, ready_a, busy_b, ready_b, busy_c, ready_c} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy_a, ready_a, busy_b, ready_b, busy_c, ready_c});
        end
        vectors++;
        if (rdata_a !== 32'h0 || rdata_b !== 32'h0 || rdata_c !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h/%h/%h want 0", rdata_a, rdata_b, rdata_c);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        int n;
        drive_a(1'b0, 16'h0010, 32'h1234_5678);
        wait_ready_a(n);
        vectors++;
        if (n !== 3) begin miscompares++; $display("FAIL wr_latency: got %0d want 3", n); end
        vectors++;
        if (busy_a !== 1'b1) begin miscompares++; $display("FAIL wr_busy_resp: got %b want 1", busy_a); end
        @(negedge clk);
        vectors++;
        if ({busy_a, ready_a} !== 2'b00) begin
            miscompares++; $display("FAIL wr_after: got %b want 00", {busy_a, ready_a});
        end
        drive_a(1'b1, 16'h0010, 32'h0);
        wait_ready_a(n);
        vectors++;
        if (n !== 3) begin miscompares++; $display("FAIL rd_latency: got %0d want 3", n); end
        vectors++;
        if (rdata_a !== 32'h1234_5678) begin
            miscompares++; $display("FAIL rd_data: got %h want 12345678", rdata_a);
        end
`ifdef MEM_RESP_ERR_EN
        vectors++;
        if (err_a !== 1'b0) begin miscompares++; $display("FAIL rd_err: got %b want 0", err_a); end
`endif
        @(negedge clk); @(negedge clk);
        vectors++;
        if (rdata_a !== 32'h1234_5678 || busy_a !== 1'b0) begin
            miscompares++; $display("FAIL rd_hold: got %h busy %b want 12345678 busy 0", rdata_a, busy_a);
        end
    endtask

    task automatic test_zero_wait;
        @(negedge clk);
        req_b = 1'b1; rw_b = 1'b0; addr_b = 16'h0005; wdata_b = 32'h0000_55AA;
        @(posedge clk);
        #1 req_b = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy_b, ready_b} !== 2'b11) begin
            miscompares++; $display("FAIL zw_wr_resp: got %b want 11", {busy_b, ready_b});
        end
        req_b = 1'b1; rw_b = 1'b1;
        @(posedge clk);   // RESP cycle: request is dropped
        #1;
        @(posedge clk);   // IDLE: request accepted here
        #1 req_b = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy_b, ready_b} !== 2'b11 || rdata_b !== 32'h0000_55AA) begin
            miscompares++;
            $display("FAIL zw_rd_resp: got %b %h want 11 000055aa", {busy_b, ready_b}, rdata_b);
        end
        @(negedge clk);
        vectors++;
        if ({busy_b, ready_b} !== 2'b00) begin
            miscompares++; $display("FAIL zw_idle: got %b want 00", {busy_b, ready_b});
        end
    endtask

    task automatic test_busy_drop;
        int pulses;
        int n;
        drive_a(1'b0, 16'h0030, 32'h1111_0001);
        @(negedge clk);   // cycle 1, WAIT
        req_a = 1'b1; rw_a = 1'b0; addr_a = 16'h0030; wdata_a = 32'h2222_0002;
        @(posedge clk);
        #1 req_a = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready_a) pulses++;
        end
        vectors++;
        if (pulses !== 1) begin miscompares++; $display("FAIL drop_pulses: got %0d want 1", pulses); end
        vectors++;
        if (rdata_a !== 32'h1234_5678) begin
            miscompares++; $display("FAIL drop_rdata_kept: got %h want 12345678", rdata_a);
        end
        drive_a(1'b1, 16'h0030, 32'h0);
        wait_ready_a(n);
        vectors++;
        if (rdata_a !== 32'h1111_0001) begin
            miscompares++; $display("FAIL drop_mem: got %h want 11110001", rdata_a);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        drive_a(1'b0, 16'h0020, 32'h0BAD_0020);
        wait_ready_a(n);
        drive_a(1'b0, 16'h0020, 32'hCAFE_0001);
        @(negedge clk);   // in WAIT
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy_a, ready_a} !== 2'b00 || rdata_a !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid: got %b %h want 00 00000000", {busy_a, ready_a}, rdata_a);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_a = 1'b1; rw_a = 1'b1; addr_a = 16'h0020;
        @(posedge clk);
        #1 req_a = 1'b0;
        wait_ready_a(n);
        vectors++;
        if (n !== 3) begin miscompares++; $display("FAIL rst_first_accept: got %0d want 3", n); end
        vectors++;
        if (rdata_a !== 32'h0BAD_0020) begin
            miscompares++; $display("FAIL rst_no_write: got %h want 0bad0020", rdata_a);
        end
    endtask

    task automatic test_range;
        int n;
        drive_a(1'b0, 16'h0000, 32'hA5A5_A5A5);
        wait_ready_a(n);
`ifdef MEM_RESP_ERR_EN
        drive_a(1'b1, 16'h0100, 32'h0);
        wait_ready_a(n);
        vectors++;
        if (n !== 3 || err_a !== 1'b1 || rdata_a !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL range_err: got n=%0d err=%b %h want 3 1 deadbeef", n, err_a, rdata_a);
        end
        @(negedge clk);
        vectors++;
        if (err_a !== 1'b0) begin miscompares++; $display("FAIL range_err_clr: got %b want 0", err_a); end
        drive_a(1'b0, 16'h0100, 32'h0BAD_BEEF);
        wait_ready_a(n);
        drive_a(1'b1, 16'h0000, 32'h0);
        wait_ready_a(n);
        vectors++;
        if (rdata_a !== 32'hA5A5_A5A5) begin
            miscompares++; $display("FAIL range_mem_kept: got %h want a5a5a5a5", rdata_a);
        end
`else
        drive_a(1'b1, 16'h0100, 32'h0);
        wait_ready_a(n);
        vectors++;
        if (rdata_a !== 32'hA5A5_A5A5) begin
            miscompares++; $display("FAIL range_alias: got %h want a5a5a5a5", rdata_a);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int pos[3];
        logic bz[16];
        int k;
        k = 0;
        for (int i = 0; i < 16; i++) bz[i] = 1'b1;
        @(negedge clk);
        req_c = 1'b1; rw_c = 1'b0; addr_c = 16'h0040; wdata_c = 32'h0000_0077;
        for (int cyc = 1; cyc < 16 && k < 3; cyc++) begin
            @(negedge clk);
            bz[cyc] = busy_c;
            if (ready_c) begin
                pos[k] = cyc;
                k++;
                if (k == 3) req_c = 1'b0;
            end
        end
        req_c = 1'b0;
        vectors++;
        if (k !== 3) begin
            miscompares++; $display("FAIL b2b_count: got %0d want 3", k);
        end else begin
            vectors++;
            if (pos[0] !== 2 || pos[1] !== 5 || pos[2] !== 8) begin
                miscompares++;
                $display("FAIL b2b_spacing: got %0d,%0d,%0d want 2,5,8", pos[0], pos[1], pos[2]);
            end
        end
        vectors++;
        if (bz[3] !== 1'b0 || bz[6] !== 1'b0) begin
            miscompares++; $display("FAIL b2b_idle_gap: got %b%b want 00", bz[3], bz[6]);
        end
        @(negedge clk); @(negedge clk);
        vectors++;
        if (busy_c !== 1'b0) begin miscompares++; $display("FAIL b2b_stop: got %b want 0", busy_c); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_zero_wait;
        test_busy_drop;
        test_reset_mid;
        test_range;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
